// File: rtl/pipe_ctrl_decoder_if.sv
// ID-stage instruction stream and registered ID/EX control bundle of pipe_ctrl_decoder.
// The master is the upstream pipeline; the slave is the decoder.
interface pipe_ctrl_decoder_if #(
    parameter int unsigned ALU_OP_W   = 3,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned CNT_W      = 8
);
    logic [31:0]           instr_i;
    logic                  instr_valid_i;
    logic                  stall_i;
    logic                  flush_i;

    logic                  RegWrite_o;
    logic                  ALUSrc_o;
    logic                  RegDst_o;
    logic                  Branch_o;
    logic                  BranchNe_o;
    logic                  MemRead_o;
    logic                  MemWrite_o;
    logic                  MemtoReg_o;
    logic                  Jump_o;
    logic [ALU_OP_W-1:0]   ALU_op_o;
    logic [REG_ADDR_W-1:0] wb_addr_o;
    logic                  ctrl_valid_o;
    logic                  illegal_o;
    logic                  hazard_stall_o;
    logic [CNT_W-1:0]      illegal_cnt_o;

    modport master (
        output instr_i, instr_valid_i, stall_i, flush_i,
        input  RegWrite_o, ALUSrc_o, RegDst_o, Branch_o, BranchNe_o, MemRead_o, MemWrite_o,
        input  MemtoReg_o, Jump_o, ALU_op_o, wb_addr_o, ctrl_valid_o, illegal_o,
        input  hazard_stall_o, illegal_cnt_o
    );

    modport slave (
        input  instr_i, instr_valid_i, stall_i, flush_i,
        output RegWrite_o, ALUSrc_o, RegDst_o, Branch_o, BranchNe_o, MemRead_o, MemWrite_o,
        output MemtoReg_o, Jump_o, ALU_op_o, wb_addr_o, ctrl_valid_o, illegal_o,
        output hazard_stall_o, illegal_cnt_o
    );
endinterface

// File: rtl/pipe_ctrl_decoder.sv
// Pipelined MIPS main-control decoder: decodes the ID opcode, registers the control bundle
// into ID/EX, and detects load-use hazards against the bundle already in ID/EX.
module pipe_ctrl_decoder #(
    parameter int unsigned ALU_OP_W   = 3,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned CNT_W      = 8,
    parameter bit          EN_HAZARD  = 1'b1
) (
    input logic                clk_i,
    input logic                rst_i,
    pipe_ctrl_decoder_if.slave bus
);

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpSlti  = 6'b001010;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpBne   = 6'b000101;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpJ     = 6'b000010;

    typedef struct packed {
        logic                  valid;
        logic                  illegal;
        logic                  reg_write;
        logic                  alu_src;
        logic                  reg_dst;
        logic                  branch;
        logic                  branch_ne;
        logic                  mem_read;
        logic                  mem_write;
        logic                  mem_to_reg;
        logic                  jump;
        logic [ALU_OP_W-1:0]   alu_op;
        logic [REG_ADDR_W-1:0] wb_addr;
    } bundle_t;

    logic [5:0]            op;
    logic [REG_ADDR_W-1:0] rs;
    logic [REG_ADDR_W-1:0] rt;
    logic [REG_ADDR_W-1:0] rd;
    logic                  unused_bits;

    assign op          = bus.instr_i[31:26];
    assign rs          = REG_ADDR_W'(bus.instr_i[25:21]);
    assign rt          = REG_ADDR_W'(bus.instr_i[20:16]);
    assign rd          = REG_ADDR_W'(bus.instr_i[15:11]);
    assign unused_bits = ^bus.instr_i[10:0];

    bundle_t          dec;
    bundle_t          bundle_q;
    logic [CNT_W-1:0] cnt_q;
    logic             rs_used;
    logic             rt_used;
    logic             load_use;
    logic             hazard;

    always_comb begin
        dec       = '0;
        dec.valid = 1'b1;
        rs_used   = 1'b1;
        rt_used   = 1'b0;
        unique case (op)
            OpRtype: begin
                dec.reg_write = 1'b1;
                dec.reg_dst   = 1'b1;
                dec.alu_op    = ALU_OP_W'(3'b010);
                rt_used       = 1'b1;
            end
            OpAddi: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.alu_op    = ALU_OP_W'(3'b110);
            end
            OpSlti: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.alu_op    = ALU_OP_W'(3'b111);
            end
            OpBeq: begin
                dec.branch = 1'b1;
                dec.alu_op = ALU_OP_W'(3'b001);
                rt_used    = 1'b1;
            end
            OpBne: begin
                dec.branch    = 1'b1;
                dec.branch_ne = 1'b1;
                dec.alu_op    = ALU_OP_W'(3'b001);
                rt_used       = 1'b1;
            end
            OpLw: begin
                dec.reg_write  = 1'b1;
                dec.alu_src    = 1'b1;
                dec.mem_read   = 1'b1;
                dec.mem_to_reg = 1'b1;
            end
            OpSw: begin
                dec.alu_src   = 1'b1;
                dec.mem_write = 1'b1;
                rt_used       = 1'b1;
            end
            OpJ: begin
                dec.jump = 1'b1;
                rs_used  = 1'b0;
            end
            default: begin
                // Loads as a valid no-op so downstream can trap on it.
                dec.illegal = 1'b1;
                rs_used     = 1'b0;
            end
        endcase
        dec.wb_addr = dec.reg_dst ? rd : rt;
    end

    // A bubble in ID/EX never has mem_read set, so a held instruction is reaccepted next cycle.
    always_comb begin
        load_use = bundle_q.valid && bundle_q.mem_read && (bundle_q.wb_addr != '0) &&
                   ((rs_used && (rs == bundle_q.wb_addr)) || (rt_used && (rt == bundle_q.wb_addr)));
        hazard   = EN_HAZARD && bus.instr_valid_i && !bus.flush_i && load_use;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bundle_q <= '0;
            cnt_q    <= '0;
        end else if (bus.flush_i) begin
            bundle_q <= '0;
        end else if (bus.stall_i) begin
            bundle_q <= bundle_q;
        end else if (hazard) begin
            bundle_q <= '0;
        end else if (bus.instr_valid_i) begin
            bundle_q <= dec;
            if (dec.illegal && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end else begin
            bundle_q <= '0;
        end
    end

    assign bus.RegWrite_o     = bundle_q.reg_write;
    assign bus.ALUSrc_o       = bundle_q.alu_src;
    assign bus.RegDst_o       = bundle_q.reg_dst;
    assign bus.Branch_o       = bundle_q.branch;
    assign bus.BranchNe_o     = bundle_q.branch_ne;
    assign bus.MemRead_o      = bundle_q.mem_read;
    assign bus.MemWrite_o     = bundle_q.mem_write;
    assign bus.MemtoReg_o     = bundle_q.mem_to_reg;
    assign bus.Jump_o         = bundle_q.jump;
    assign bus.ALU_op_o       = bundle_q.alu_op;
    assign bus.wb_addr_o      = bundle_q.wb_addr;
    assign bus.ctrl_valid_o   = bundle_q.valid;
    assign bus.illegal_o      = bundle_q.illegal;
    assign bus.hazard_stall_o = hazard;
    assign bus.illegal_cnt_o  = cnt_q;

endmodule

// File: tb/tb_pipe_ctrl_decoder.sv
// Randomized and directed checks of three pipe_ctrl_decoder builds against a table-driven
// reference model: default, CNT_W = 2, and ALU_OP_W = 4 with EN_HAZARD = 0.
module tb_pipe_ctrl_decoder;

    logic        clk;
    logic        rst;
    logic [31:0] instr;
    logic        vld;
    logic        stl;
    logic        fls;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    pipe_ctrl_decoder_if #(.ALU_OP_W(3), .REG_ADDR_W(5), .CNT_W(8)) if0 ();
    pipe_ctrl_decoder_if #(.ALU_OP_W(3), .REG_ADDR_W(5), .CNT_W(2)) if1 ();
    pipe_ctrl_decoder_if #(.ALU_OP_W(4), .REG_ADDR_W(5), .CNT_W(8)) if2 ();

    assign if0.instr_i = instr;  assign if0.instr_valid_i = vld;
    assign if0.stall_i = stl;    assign if0.flush_i       = fls;
    assign if1.instr_i = instr;  assign if1.instr_valid_i = vld;
    assign if1.stall_i = stl;    assign if1.flush_i       = fls;
    assign if2.instr_i = instr;  assign if2.instr_valid_i = vld;
    assign if2.stall_i = stl;    assign if2.flush_i       = fls;

    pipe_ctrl_decoder #(.ALU_OP_W(3), .REG_ADDR_W(5), .CNT_W(8), .EN_HAZARD(1'b1)) u0 (
        .clk_i(clk), .rst_i(rst), .bus(if0));
    pipe_ctrl_decoder #(.ALU_OP_W(3), .REG_ADDR_W(5), .CNT_W(2), .EN_HAZARD(1'b1)) u1 (
        .clk_i(clk), .rst_i(rst), .bus(if1));
    pipe_ctrl_decoder #(.ALU_OP_W(4), .REG_ADDR_W(5), .CNT_W(8), .EN_HAZARD(1'b0)) u2 (
        .clk_i(clk), .rst_i(rst), .bus(if2));

    // ctrl order: RegWrite ALUSrc RegDst Branch BranchNe MemRead MemWrite MemtoReg Jump
    typedef struct packed {
        logic       valid;
        logic       illegal;
        logic [8:0] ctrl;
        logic [3:0] alu;
        logic [4:0] wb;
        logic [7:0] cnt;
        logic       hz;
    } out_t;

    out_t obs [3];
    assign obs[0] = {if0.ctrl_valid_o, if0.illegal_o, if0.RegWrite_o, if0.ALUSrc_o, if0.RegDst_o,
                     if0.Branch_o, if0.BranchNe_o, if0.MemRead_o, if0.MemWrite_o, if0.MemtoReg_o,
                     if0.Jump_o, 1'b0, if0.ALU_op_o, if0.wb_addr_o, if0.illegal_cnt_o,
                     if0.hazard_stall_o};
    assign obs[1] = {if1.ctrl_valid_o, if1.illegal_o, if1.RegWrite_o, if1.ALUSrc_o, if1.RegDst_o,
                     if1.Branch_o, if1.BranchNe_o, if1.MemRead_o, if1.MemWrite_o, if1.MemtoReg_o,
                     if1.Jump_o, 1'b0, if1.ALU_op_o, if1.wb_addr_o, 6'b0, if1.illegal_cnt_o,
                     if1.hazard_stall_o};
    assign obs[2] = {if2.ctrl_valid_o, if2.illegal_o, if2.RegWrite_o, if2.ALUSrc_o, if2.RegDst_o,
                     if2.Branch_o, if2.BranchNe_o, if2.MemRead_o, if2.MemWrite_o, if2.MemtoReg_o,
                     if2.Jump_o, if2.ALU_op_o, if2.wb_addr_o, if2.illegal_cnt_o,
                     if2.hazard_stall_o};

    typedef struct {
        bit [5:0] op;
        bit [8:0] ctrl;
        int       alu;
        bit       rs_use;
        bit       rt_use;
    } row_t;

    typedef struct {
        bit       valid;
        bit       illegal;
        bit [8:0] ctrl;
        int       alu;
        int       wb;
        int       cnt;
    } model_t;

    row_t   rows [8];
    model_t mdl [3];
    int     cnt_max [3] = '{255, 3, 255};
    bit     en_hz [3]   = '{1'b1, 1'b1, 1'b0};
    int     n_cmp = 0;
    int     n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    function automatic int find_row(input bit [5:0] op);
        for (int k = 0; k < 8; k++) if (rows[k].op == op) return k;
        return -1;
    endfunction

    function automatic bit ref_hazard(input int i);
        int r;
        int rs_f;
        int rt_f;
        r    = find_row(instr[31:26]);
        rs_f = int'(instr[25:21]);
        rt_f = int'(instr[20:16]);
        if (!en_hz[i] || !vld || fls) return 1'b0;
        if (!mdl[i].valid || !mdl[i].ctrl[3] || mdl[i].wb == 0 || r < 0) return 1'b0;
        return (rows[r].rs_use && rs_f == mdl[i].wb) || (rows[r].rt_use && rt_f == mdl[i].wb);
    endfunction

    function automatic logic [31:0] mk(input bit [5:0] op, input int rs_f, input int rt_f,
                                       input int rd_f);
        logic [31:0] w;
        w = {op, rs_f[4:0], rt_f[4:0], rd_f[4:0], 11'($urandom)};
        return w;
    endfunction

    task automatic cycle(input logic [31:0] ins, input bit v, input bit s, input bit f,
                         input bit r);
        bit     hz [3];
        int     row;
        model_t bubble;
        @(negedge clk);
        instr = ins; vld = v; stl = s; fls = f; rst = r;
        #1;
        for (int i = 0; i < 3; i++) begin
            hz[i] = ref_hazard(i);
            check_eq($sformatf("u%0d.hazard", i), 32'(obs[i].hz), 32'(hz[i]));
        end
        row = find_row(ins[31:26]);
        for (int i = 0; i < 3; i++) begin
            bubble     = '{default: 0};
            bubble.cnt = mdl[i].cnt;
            if (r) mdl[i] = '{default: 0};
            else if (f) mdl[i] = bubble;
            else if (s) mdl[i] = mdl[i];
            else if (hz[i]) mdl[i] = bubble;
            else if (v && row >= 0) begin
                mdl[i].valid   = 1'b1;
                mdl[i].illegal = 1'b0;
                mdl[i].ctrl    = rows[row].ctrl;
                mdl[i].alu     = rows[row].alu;
                mdl[i].wb      = rows[row].ctrl[6] ? int'(ins[15:11]) : int'(ins[20:16]);
            end else if (v) begin
                mdl[i].valid   = 1'b1;
                mdl[i].illegal = 1'b1;
                mdl[i].ctrl    = '0;
                mdl[i].alu     = 0;
                mdl[i].wb      = int'(ins[20:16]);
                if (mdl[i].cnt < cnt_max[i]) mdl[i].cnt++;
            end else mdl[i] = bubble;
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("u%0d.valid", i), 32'(obs[i].valid), 32'(mdl[i].valid));
            check_eq($sformatf("u%0d.illegal", i), 32'(obs[i].illegal), 32'(mdl[i].illegal));
            check_eq($sformatf("u%0d.ctrl", i), 32'(obs[i].ctrl), 32'(mdl[i].ctrl));
            check_eq($sformatf("u%0d.alu_op", i), 32'(obs[i].alu), mdl[i].alu);
            check_eq($sformatf("u%0d.wb_addr", i), 32'(obs[i].wb), mdl[i].wb);
            check_eq($sformatf("u%0d.ill_cnt", i), 32'(obs[i].cnt), mdl[i].cnt);
        end
    endtask

    initial begin
        rows[0] = '{6'b000000, 9'b101000000, 2, 1'b1, 1'b1};  // R-format
        rows[1] = '{6'b001000, 9'b110000000, 6, 1'b1, 1'b0};  // addi
        rows[2] = '{6'b001010, 9'b110000000, 7, 1'b1, 1'b0};  // slti
        rows[3] = '{6'b000100, 9'b000100000, 1, 1'b1, 1'b1};  // beq
        rows[4] = '{6'b000101, 9'b000110000, 1, 1'b1, 1'b1};  // bne
        rows[5] = '{6'b100011, 9'b110001010, 0, 1'b1, 1'b0};  // lw
        rows[6] = '{6'b101011, 9'b010000100, 0, 1'b1, 1'b1};  // sw
        rows[7] = '{6'b000010, 9'b000000001, 0, 1'b0, 1'b0};  // j
        for (int i = 0; i < 3; i++) mdl[i] = '{default: 0};

        instr = '0; vld = 1'b0; stl = 1'b0; fls = 1'b0; rst = 1'b1;
        repeat (2) @(posedge clk);

        cycle(32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        // Every legal opcode back to back.
        cycle(mk(6'b000000, 1, 2, 3), 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(mk(6'b001000, 4, 6, 9), 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(mk(6'b001010, 4, 8, 9), 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(mk(6'b000100, 1, 2, 0), 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(mk(6'b000101, 1, 2, 0), 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(mk(6'b100011, 1, 7, 0), 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(mk(6'b101011, 2, 3, 0), 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(mk(6'b000010, 5, 5, 5), 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        // Load-use: stall once, then accept the held add.
        cycle(mk(6'b100011, 1, 5, 0), 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(mk(6'b000000, 5, 2, 3), 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(mk(6'b000000, 5, 2, 3), 1'b1, 1'b0, 1'b0, 1'b0);
        // Load to $0 and a jump reading rs=5 never stall.
        cycle(mk(6'b100011, 1, 0, 0), 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(mk(6'b000000, 0, 0, 3), 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(mk(6'b100011, 1, 5, 0), 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(mk(6'b000010, 5, 0, 0), 1'b1, 1'b0, 1'b0, 1'b0);
        // Stall freezes for three cycles, then stall+flush loads a bubble.
        cycle(mk(6'b001000, 3, 4, 0), 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (3) cycle(mk(6'b000100, 1, 2, 0), 1'b1, 1'b1, 1'b0, 1'b0);
        cycle(mk(6'b000100, 1, 2, 0), 1'b1, 1'b1, 1'b1, 1'b0);
        // Flush during a would-be hazard, and stall overlapping a hazard.
        cycle(mk(6'b100011, 1, 5, 0), 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(mk(6'b000000, 5, 2, 3), 1'b1, 1'b0, 1'b1, 1'b0);
        cycle(mk(6'b100011, 1, 6, 0), 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(mk(6'b101011, 1, 6, 0), 1'b1, 1'b1, 1'b0, 1'b0);
        cycle(mk(6'b101011, 1, 6, 0), 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(mk(6'b101011, 1, 6, 0), 1'b1, 1'b0, 1'b0, 1'b0);
        // Illegal opcodes; the 2-bit counter saturates at 3.
        repeat (6) cycle(mk(6'b111111, 1, 2, 3), 1'b1, 1'b0, 1'b0, 1'b0);
        // Reset while a hazard is pending.
        cycle(mk(6'b100011, 1, 5, 0), 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(mk(6'b000000, 5, 2, 3), 1'b1, 1'b0, 1'b0, 1'b1);
        cycle(mk(6'b000000, 5, 2, 3), 1'b1, 1'b0, 1'b0, 1'b0);

        for (int n = 0; n < 3000; n++) begin
            int          sel;
            logic [5:0]  op;
            logic [31:0] w;
            sel = int'($urandom_range(0, 9));
            if (sel < 8) op = rows[sel].op;
            else if (sel == 8) op = 6'b111111;
            else op = 6'($urandom);
            w = mk(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 3)));
            cycle(w, ($urandom_range(0, 7) != 0), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 9) == 0), ($urandom_range(0, 59) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl_decoder.md
# pipe_ctrl_decoder

Pipelined main-control decoder for the MIPS datapath. It decodes the 6-bit opcode of the instruction in ID and registers the control bundle into the ID/EX boundary with one cycle of latency. It supports stall, flush and load-use hazard detection. It extends the single-cycle decoder's set (addi, slti, R-format, beq) with bne, lw, sw and j, and the ALU-op width is parametrised.

## Interface
- ALU_OP_W, 3, width of ALU_op_o; must be ≥3; encodings are zero-extended.
- REG_ADDR_W, 5, register-address width.
- CNT_W, 8, width of the illegal-opcode counter.
- EN_HAZARD, 1, 1 enables load-use detection; 0 ties hazard_stall_o low.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- instr_i  in  32  ID-stage instruction: op = [31:26], rs = [25:21], rt = [20:16], rd = [15:11].
- instr_valid_i  in  1  instr_i holds a real instruction.
- stall_i  in  1  downstream hold; the output register keeps its value.
- flush_i  in  1  kill; the next registered bundle is a bubble.
- RegWrite_o, ALUSrc_o, RegDst_o, Branch_o, BranchNe_o, MemRead_o, MemWrite_o, MemtoReg_o, Jump_o  out  1 each  registered control bits.
- ALU_op_o  out  ALU_OP_W  registered ALU op.
- wb_addr_o  out  REG_ADDR_W  registered destination register: rd if RegDst, else rt.
- ctrl_valid_o  out  1  the registered bundle is a real instruction.
- illegal_o  out  1  the registered bundle came from an unknown opcode.
- hazard_stall_o  out  1  combinational; upstream must hold PC and IF/ID this cycle.
- illegal_cnt_o  out  CNT_W  saturating count of accepted illegal opcodes.

## Operation
- Decode is combinational on op. Any bit not listed below is 0.
  - R-format 000000: RegWrite, RegDst, ALU_op 010.
  - addi 001000: RegWrite, ALUSrc, ALU_op 110.
  - slti 001010: RegWrite, ALUSrc, ALU_op 111.
  - beq 000100: Branch, ALU_op 001.
  - bne 000101: Branch, BranchNe, ALU_op 001.
  - lw 100011: RegWrite, ALUSrc, MemRead, MemtoReg, ALU_op 000.
  - sw 101011: ALUSrc, MemWrite, ALU_op 000.
  - j 000010: Jump, ALU_op 000.
  - Any other op: all control bits 0 and illegal = 1.
- Bubble: all outputs except illegal_cnt_o are 0.
- Source use:
  - rs is used by every legal opcode except j.
  - rt is used as a source by R-format, beq, bne and sw.
- Hazard: asserted when all of the following hold:
  - EN_HAZARD = 1, instr_valid_i = 1 and flush_i = 0;
  - ctrl_valid_o = 1 and MemRead_o = 1;
  - wb_addr_o ≠ 0;
  - (rs used and rs = wb_addr_o) or (rt used and rt = wb_addr_o).
- hazard_stall_o equals the hazard term in the same cycle.
- Register update priority, highest first:
  1. rst_i: all outputs 0 and illegal_cnt_o = 0.
  2. flush_i: load a bubble; stall_i and hazard are ignored.
  3. stall_i: hold everything, including the counter.
  4. hazard: load a bubble.
  5. instr_valid_i = 1: load the decoded bundle.
  6. Otherwise: load a bubble.
- Counter: illegal_cnt_o increments only when an illegal bundle is loaded (priority 5 with an illegal op). It saturates at 2^CNT_W − 1 with no wrap.
- An illegal instruction loads with ctrl_valid_o = 1 and illegal_o = 1. Downstream treats it as a no-op.

## Timing
- Latency: the decoded bundle appears one cycle after it is presented with instr_valid_i = 1 and no stall, flush or hazard.
- A load-use hazard costs exactly one bubble cycle. Upstream holds instr_i, so it is reaccepted the next cycle, because a bubble never triggers a hazard.
- Throughput: one instruction per cycle when there are no stalls or hazards.
- Reset mid-operation: the next edge clears the state regardless of the other inputs. hazard_stall_o is 0 in the cycle after reset because ctrl_valid_o = 0.
- Simultaneous stall_i and hazard: stall_i wins and the lw stays registered. hazard_stall_o stays high, and the bubble is inserted on the first cycle with stall_i = 0.

## Test plan
- Reset, then present each of the 8 legal opcodes on consecutive cycles:
  - each bundle matches the decode list one cycle later;
  - for addi, ALU_op_o = 3'b110 and wb_addr_o = rt;
  - for R-format, wb_addr_o = rd.
- Load-use: lw with rt = 5, then add with rs = 5:
  - hazard_stall_o = 1 for exactly one cycle;
  - one bubble, then the add bundle;
  - repeat with rt = 0, and with a j instruction using field rs = 5: no stall in either case.
- Stall and flush:
  - stall_i for 3 cycles: outputs frozen;
  - stall_i and flush_i together: a bubble is loaded;
  - flush_i during a hazard: hazard_stall_o = 0 and a bubble is loaded.
- Illegal opcode 111111 with instr_valid_i = 1:
  - ctrl_valid_o = 1, illegal_o = 1 and every control bit 0;
  - illegal_cnt_o increments by 1;
  - with CNT_W = 2 and 5 illegal instructions, illegal_cnt_o holds at 3.
- Reset asserted mid-stream while the lw hazard is active: the next cycle has all outputs 0, illegal_cnt_o = 0 and hazard_stall_o = 0.
- Build with ALU_OP_W = 4 and EN_HAZARD = 0: slti gives ALU_op_o = 4'b0111, and the lw/add sequence produces no stall.
